// File: rtl/mem_read_responder_pkg.sv
// Shared definitions for the memory read responder.
//   state_e         : responder FSM states
//   ERR_DATA        : word returned for out-of-range reads
//   addr_in_range() : true when a byte address falls inside a 2**aw word store
package mem_read_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  // Everything above the word index must be zero; there is no wrap-around.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage for the read responder: one write port and one synchronous
// read port with read-first behaviour (a same-edge write to the read word
// is not seen by that read). No reset, so contents survive reset.
// Ports:
//   clk              : clock
//   wr_en/wr_idx/wr_data : write port, commits on the rising edge
//   rd_en/rd_idx     : read strobe and word index
//   rd_data          : registered read word, holds while rd_en is low
module mem_word_array #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = "",
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  // Power-up contents: zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_read_responder.sv
// Fixed-latency memory read responder. A level read request is accepted in
// IDLE; the addressed word is read at the accept edge and presented with a
// one-cycle response pulse LATENCY cycles later. Out-of-range reads return
// ERR_DATA with memory_read_error set. A loader write port is always live.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   memory_read_request/addr    : level request and byte address
//   memory_read_response        : one-cycle pulse, data valid
//   memory_read_data            : read word (holds last value outside RESP)
//   memory_read_error           : out-of-range flag, only with the response
//   write_enable/addr/data      : loader write port
module mem_read_responder
  import mem_read_responder_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read_request,
  input  logic [31:0] memory_addr,
  output logic        memory_read_response,
  output logic [31:0] memory_read_data,
  output logic        memory_read_error,
  input  logic        write_enable,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] hold_q, hold_d;

  logic        accept;
  logic        rd_ok;
  logic        wr_ok;
  logic [31:0] ram_rdata;
  logic [31:0] resp_data;

  assign rd_ok  = addr_in_range(memory_addr, AW);
  assign wr_ok  = addr_in_range(write_addr, AW);
  assign accept = (state_q == IDLE) && memory_read_request;

  // The RAM output register is the latched word: it is only reloaded on an
  // accept, so later writes cannot disturb a read already in flight.
  mem_word_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (write_enable && wr_ok),
    .wr_idx  (write_addr[AW+1:2]),
    .wr_data (write_data),
    .rd_en   (accept),
    .rd_idx  (memory_addr[AW+1:2]),
    .rd_data (ram_rdata)
  );

  assign resp_data = err_q ? ERR_DATA : ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (memory_read_request) begin
          err_d   = !rd_ok;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        // Remember what was shown so the data output holds after the pulse.
        hold_d  = resp_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign memory_read_response = (state_q == RESP);
  assign memory_read_error    = (state_q == RESP) && err_q;
  assign memory_read_data     = (state_q == RESP) ? resp_data : hold_q;

endmodule

// File: tb/tb_mem_read_responder.sv
module tb_mem_read_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Three responders: [0] LATENCY=2 DEPTH=1024, [1] LATENCY=1 DEPTH=1024,
  // [2] LATENCY=4 DEPTH=64.
  localparam int LAT [3] = '{2, 1, 4};
  localparam int DEP [3] = '{1024, 1024, 64};

  logic        rst  [3];
  logic        req  [3];
  logic [31:0] addr [3];
  logic        we   [3];
  logic [31:0] wa   [3];
  logic [31:0] wd   [3];
  logic        resp [3];
  logic        err  [3];
  logic [31:0] dat  [3];

  mem_read_responder #(.DEPTH(1024), .LATENCY(2), .INIT_FILE("")) u_lat2 (
    .clk(clk), .reset(rst[0]), .memory_read_request(req[0]), .memory_addr(addr[0]),
    .memory_read_response(resp[0]), .memory_read_data(dat[0]), .memory_read_error(err[0]),
    .write_enable(we[0]), .write_addr(wa[0]), .write_data(wd[0]));

  mem_read_responder #(.DEPTH(1024), .LATENCY(1), .INIT_FILE("")) u_lat1 (
    .clk(clk), .reset(rst[1]), .memory_read_request(req[1]), .memory_addr(addr[1]),
    .memory_read_response(resp[1]), .memory_read_data(dat[1]), .memory_read_error(err[1]),
    .write_enable(we[1]), .write_addr(wa[1]), .write_data(wd[1]));

  mem_read_responder #(.DEPTH(64), .LATENCY(4), .INIT_FILE("")) u_lat4 (
    .clk(clk), .reset(rst[2]), .memory_read_request(req[2]), .memory_addr(addr[2]),
    .memory_read_response(resp[2]), .memory_read_data(dat[2]), .memory_read_error(err[2]),
    .write_enable(we[2]), .write_addr(wa[2]), .write_data(wd[2]));

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request is taken whenever the responder is free,
  // answered LATENCY cycles later, and the responder is free again the cycle
  // after the answer. The word is sampled before any same-edge write.
  logic [31:0] mm [3][1024];
  int          rem      [3];
  bit          rn       [3];
  bit          perr     [3];
  logic [31:0] pdat     [3];
  bit          exp_resp [3];
  bit          exp_err  [3];
  logic [31:0] exp_dat  [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 1024; j++) mm[i][j] = 32'h0;
      rem[i] = 0; rn[i] = 1'b0; perr[i] = 1'b0; pdat[i] = 32'h0;
      exp_resp[i] = 1'b0; exp_err[i] = 1'b0; exp_dat[i] = 32'h0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst[i]) begin
          rem[i] = 0; rn[i] = 1'b0; exp_dat[i] = 32'h0;
        end else if (rn[i]) begin
          rn[i] = 1'b0;
        end else if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) rn[i] = 1'b1;
        end else if (req[i]) begin
          perr[i] = !(addr[i] < 32'(DEP[i] * 4));
          pdat[i] = perr[i] ? 32'h0 : mm[i][addr[i][11:2]];
          rem[i]  = LAT[i] - 1;
          if (rem[i] == 0) rn[i] = 1'b1;
        end
        if (rn[i]) exp_dat[i] = pdat[i];
        exp_resp[i] = rn[i];
        exp_err[i]  = rn[i] && perr[i];
        if (we[i] && (wa[i] < 32'(DEP[i] * 4))) mm[i][wa[i][11:2]] = wd[i];
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("resp[%0d]", i), {31'b0, resp[i]}, {31'b0, exp_resp[i]});
          chk($sformatf("err[%0d]", i), {31'b0, err[i]}, {31'b0, exp_err[i]});
          chk($sformatf("data[%0d]", i), dat[i], exp_dat[i]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d);
    we[i] = 1'b1; wa[i] = a; wd[i] = d;
    tick(1);
    we[i] = 1'b0;
  endtask

  // Hold the request until the response is seen; report cycles from the
  // accept cycle to the response, and the response data/error. Returns one
  // cycle after the response so the next request is not ignored.
  task automatic rd(input int i, input logic [31:0] a, output int k,
                    output logic [31:0] d, output logic e);
    req[i] = 1'b1; addr[i] = a; k = -1; d = 32'hx; e = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (resp[i]) begin
        k = c; d = dat[i]; e = err[i];
        break;
      end
    end
    req[i] = 1'b0;
    tick(1);
  endtask

  int          k;
  logic [31:0] d;
  logic        e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; addr[i] = 32'h0;
      we[i] = 1'b0; wa[i] = 32'h0; wd[i] = 32'h0;
    end
    tick(1);
    chk_on = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    chk("reset_resp", {31'b0, resp[0]}, 32'h0);
    chk("reset_data", dat[0], 32'h0);
    chk("reset_err", {31'b0, err[2]}, 32'h0);

    // LATENCY=2: preloaded word 3 returned two cycles after accept.
    wr(0, 32'h0C, 32'hDEAD_BEEF);
    rd(0, 32'h0C, k, d, e);
    chk("l2_latency", 32'(k), 32'd2);
    chk("l2_data", d, 32'hDEAD_BEEF);
    chk("l2_err", {31'b0, e}, 32'h0);

    // Out-of-range read then an in-range read.
    wr(0, 32'h0, 32'hA5A5_0001);
    rd(0, 32'h0000_1000, k, d, e);
    chk("oor_data", d, 32'h0);
    chk("oor_err", {31'b0, e}, 32'h1);
    rd(0, 32'h0, k, d, e);
    chk("after_oor_err", {31'b0, e}, 32'h0);
    chk("after_oor_data", d, 32'hA5A5_0001);

    // Misaligned address returns the containing word.
    wr(0, 32'h4, 32'h1111_2222);
    rd(0, 32'h7, k, d, e);
    chk("misalign_7", d, 32'h1111_2222);
    rd(0, 32'h4, k, d, e);
    chk("aligned_4", d, 32'h1111_2222);

    // Same-edge write is not seen by the read; a following read sees it.
    wr(0, 32'h8, 32'hCAFE_0008);
    req[0] = 1'b1; addr[0] = 32'h8;
    we[0] = 1'b1; wa[0] = 32'h8; wd[0] = 32'h1234_5678;
    tick(1);
    we[0] = 1'b0;
    tick(1);
    chk("rf_resp", {31'b0, resp[0]}, 32'h1);
    chk("rf_old", dat[0], 32'hCAFE_0008);
    req[0] = 1'b0;
    tick(1);
    rd(0, 32'h8, k, d, e);
    chk("rf_new", d, 32'h1234_5678);

    // Write during WAIT is not visible to the in-flight read.
    req[0] = 1'b1; addr[0] = 32'h14;
    tick(1);
    we[0] = 1'b1; wa[0] = 32'h14; wd[0] = 32'h0000_5A5A;
    tick(1);
    we[0] = 1'b0;
    chk("wait_wr_data", dat[0], 32'h0);
    req[0] = 1'b0;
    tick(1);
    rd(0, 32'h14, k, d, e);
    chk("wait_wr_later", d, 32'h0000_5A5A);

    // Out-of-range write dropped; last in-range word works.
    wr(0, 32'h0000_1008, 32'hFFFF_FFFF);
    rd(0, 32'h8, k, d, e);
    chk("oor_wr_drop", d, 32'h1234_5678);
    wr(0, 32'h0FFC, 32'h0FFC_0FFC);
    rd(0, 32'h0FFC, k, d, e);
    chk("last_word", d, 32'h0FFC_0FFC);
    chk("last_word_err", {31'b0, e}, 32'h0);

    // LATENCY=1: request held across responses -> back-to-back reads.
    wr(1, 32'h0, 32'h0000_AAAA);
    wr(1, 32'h4, 32'h0000_BBBB);
    req[1] = 1'b1; addr[1] = 32'h0;
    tick(1);
    chk("l1_resp0", {31'b0, resp[1]}, 32'h1);
    chk("l1_data0", dat[1], 32'h0000_AAAA);
    addr[1] = 32'h4;
    tick(1);
    chk("l1_gap", {31'b0, resp[1]}, 32'h0);
    tick(1);
    chk("l1_resp1", {31'b0, resp[1]}, 32'h1);
    chk("l1_data1", dat[1], 32'h0000_BBBB);
    req[1] = 1'b0;
    tick(1);
    chk("l1_hold", dat[1], 32'h0000_BBBB);

    // LATENCY=4: reset mid-WAIT kills the response.
    wr(2, 32'h20, 32'h4444_0020);
    req[2] = 1'b1; addr[2] = 32'h20;
    tick(2);
    rst[2] = 1'b1; req[2] = 1'b0;
    tick(1);
    rst[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("l4_no_resp", {31'b0, resp[2]}, 32'h0);
    end

    // Write during reset commits; request right after release is accepted.
    rst[2] = 1'b1; we[2] = 1'b1; wa[2] = 32'h24; wd[2] = 32'h5555_0024;
    tick(1);
    rst[2] = 1'b0; we[2] = 1'b0;
    rd(2, 32'h24, k, d, e);
    chk("l4_latency", 32'(k), 32'd4);
    chk("l4_rst_wr", d, 32'h5555_0024);
    rd(2, 32'h20, k, d, e);
    chk("l4_after_rst", d, 32'h4444_0020);
    rd(2, 32'h100, k, d, e);
    chk("l4_oor_err", {31'b0, e}, 32'h1);
    chk("l4_oor_data", d, 32'h0);
    rd(2, 32'hFC, k, d, e);
    chk("l4_top_err", {31'b0, e}, 32'h0);

    tick(2);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
